// File: rtl/udma_hyper_phy_trans.sv
// Phy-domain HyperBus transaction sequencer: takes one toggle-handshaked request
// from the sys domain, walks it through CS/command/latency/data/recovery phases.
module udma_hyper_phy_trans #(
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned LAT_W     = 4,
    parameter int unsigned RECOV_CYC = 2
) (
    input  logic             phy_clk_i,
    input  logic             rst_ni,
    input  logic             req_tgl_i,
    input  logic             req_proc_id_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [LAT_W-1:0] req_lat_i,
    output logic             ack_tgl_o,
    output logic             cs_no,
    output logic             ca_valid_o,
    input  logic             ca_ready_i,
    input  logic             data_valid_i,
    output logic             running_trans_o,
    output logic             proc_id_o,
    output logic             trans_done_o
);

    localparam int unsigned       RC_W       = $clog2(RECOV_CYC + 1);
    localparam logic [RC_W-1:0]   RECOV_LOAD = RC_W'(RECOV_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LAT,
        ST_DATA,
        ST_RECOV
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             seen_q, seen_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [RC_W-1:0]  recov_cnt_q, recov_cnt_d;
    logic             cs_n_q, cs_n_d;
    logic             running_q, running_d;
    logic             proc_id_q, proc_id_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;

    always_ff @(posedge phy_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            seen_q      <= 1'b0;
            len_q       <= '0;
            lat_q       <= '0;
            lat_cnt_q   <= '0;
            word_cnt_q  <= '0;
            recov_cnt_q <= '0;
            cs_n_q      <= 1'b1;
            running_q   <= 1'b0;
            proc_id_q   <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= req_tgl_i;
            sync2_q     <= sync1_q;
            seen_q      <= seen_d;
            len_q       <= len_d;
            lat_q       <= lat_d;
            lat_cnt_q   <= lat_cnt_d;
            word_cnt_q  <= word_cnt_d;
            recov_cnt_q <= recov_cnt_d;
            cs_n_q      <= cs_n_d;
            running_q   <= running_d;
            proc_id_q   <= proc_id_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seen_d      = seen_q;
        len_d       = len_q;
        lat_d       = lat_q;
        lat_cnt_d   = lat_cnt_q;
        word_cnt_d  = word_cnt_q;
        recov_cnt_d = recov_cnt_q;
        cs_n_d      = cs_n_q;
        running_d   = running_q;
        proc_id_d   = proc_id_q;
        ack_d       = ack_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A toggle edge not yet consumed means a new request is waiting.
                if (sync2_q != seen_q) begin
                    seen_d    = sync2_q;
                    len_d     = req_len_i;
                    lat_d     = req_lat_i;
                    running_d = 1'b1;
                    proc_id_d = req_proc_id_i;
                    if (req_len_i == '0) begin
                        recov_cnt_d = RECOV_LOAD;
                        state_d     = ST_RECOV;
                    end else begin
                        cs_n_d  = 1'b0;
                        state_d = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (ca_ready_i) begin
                    if (lat_q == '0) begin
                        word_cnt_d = len_q;
                        state_d    = ST_DATA;
                    end else begin
                        lat_cnt_d = lat_q;
                        state_d   = ST_LAT;
                    end
                end
            end
            ST_LAT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    word_cnt_d = len_q;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_valid_i) begin
                    word_cnt_d = word_cnt_q - LEN_W'(1);
                    if (word_cnt_q == LEN_W'(1)) begin
                        cs_n_d      = 1'b1;
                        recov_cnt_d = RECOV_LOAD;
                        state_d     = ST_RECOV;
                    end
                end
            end
            ST_RECOV: begin
                recov_cnt_d = recov_cnt_q - RC_W'(1);
                if (recov_cnt_q == RC_W'(1)) begin
                    running_d = 1'b0;
                    ack_d     = ~ack_q;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ca_valid_o      = (state_q == ST_CMD);
    assign cs_no           = cs_n_q;
    assign running_trans_o = running_q;
    assign proc_id_o       = proc_id_q;
    assign ack_tgl_o       = ack_q;
    assign trans_done_o    = done_q;

endmodule

// File: tb/tb_udma_hyper_phy_trans.sv
// Directed bench for udma_hyper_phy_trans; outputs sampled on negedge, where
// k counts rising edges since the request toggle (k=3 is the accept edge).
module tb_udma_hyper_phy_trans;

    logic        phy_clk_i = 1'b0;
    logic        rst_ni;
    logic        req_tgl_i;
    logic        req_proc_id_i;
    logic [15:0] req_len_i;
    logic [3:0]  req_lat_i;
    logic        ack_tgl_o;
    logic        cs_no;
    logic        ca_valid_o;
    logic        ca_ready_i;
    logic        data_valid_i;
    logic        running_trans_o;
    logic        proc_id_o;
    logic        trans_done_o;
    logic [4:0]  obs;

    int tests = 0;
    int fails = 0;

    udma_hyper_phy_trans #(.LEN_W(16), .LAT_W(4), .RECOV_CYC(2)) dut (
        .phy_clk_i       (phy_clk_i),
        .rst_ni          (rst_ni),
        .req_tgl_i       (req_tgl_i),
        .req_proc_id_i   (req_proc_id_i),
        .req_len_i       (req_len_i),
        .req_lat_i       (req_lat_i),
        .ack_tgl_o       (ack_tgl_o),
        .cs_no           (cs_no),
        .ca_valid_o      (ca_valid_o),
        .ca_ready_i      (ca_ready_i),
        .data_valid_i    (data_valid_i),
        .running_trans_o (running_trans_o),
        .proc_id_o       (proc_id_o),
        .trans_done_o    (trans_done_o)
    );

    always #5 phy_clk_i = ~phy_clk_i;

    // {cs_no, ca_valid, running, ack, done}
    assign obs = {cs_no, ca_valid_o, running_trans_o, ack_tgl_o, trans_done_o};

    task automatic test_reset();
        rst_ni = 1'b0; req_tgl_i = 1'b0; req_proc_id_i = 1'b0;
        req_len_i = '0; req_lat_i = '0; ca_ready_i = 1'b0; data_valid_i = 1'b0;
        repeat (2) @(negedge phy_clk_i);
        tests++;
        if (obs !== 5'b10000 || proc_id_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: got %b/%b exp 10000/0", obs, proc_id_o);
        end
        rst_ni = 1'b1;
        repeat (3) @(negedge phy_clk_i);
        tests++;
        if (obs !== 5'b10000) begin
            fails++;
            $display("FAIL reset_release_idle: got %b exp 10000", obs);
        end
    endtask

    task automatic test_basic();
        logic a0;
        logic [4:0] exp;
        req_len_i = 16'd4; req_lat_i = 4'd2; req_proc_id_i = 1'b0;
        ca_ready_i = 1'b1; data_valid_i = 1'b1;
        a0 = ack_tgl_o;
        req_tgl_i = ~req_tgl_i;
        for (int k = 1; k <= 14; k++) begin
            @(negedge phy_clk_i);
            exp = {!(k >= 3 && k < 10), k == 3, (k >= 3 && k < 12), a0 ^ (k >= 12), k == 12};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL basic k=%0d: got %b exp %b", k, obs, exp);
            end
        end
    endtask

    task automatic test_len0();
        logic a0;
        logic [4:0] exp;
        req_len_i = 16'd0; req_lat_i = 4'd3; req_proc_id_i = 1'b1;
        a0 = ack_tgl_o;
        req_tgl_i = ~req_tgl_i;
        for (int k = 1; k <= 8; k++) begin
            @(negedge phy_clk_i);
            exp = {1'b1, 1'b0, (k == 3 || k == 4), a0 ^ (k >= 5), k == 5};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL len0 k=%0d: got %b exp %b", k, obs, exp);
            end
            if (k >= 3) begin
                tests++;
                if (proc_id_o !== 1'b1) begin
                    fails++;
                    $display("FAIL len0_proc_id k=%0d: got %b exp 1", k, proc_id_o);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic a0;
        logic [4:0] exp;
        req_len_i = 16'd1; req_lat_i = 4'd0; req_proc_id_i = 1'b0;
        ca_ready_i = 1'b0; data_valid_i = 1'b1;
        a0 = ack_tgl_o;
        req_tgl_i = ~req_tgl_i;
        for (int k = 1; k <= 14; k++) begin
            @(negedge phy_clk_i);
            exp = {!(k >= 3 && k < 10), (k >= 3 && k <= 8), (k >= 3 && k < 12),
                   a0 ^ (k >= 12), k == 12};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL stall k=%0d: got %b exp %b", k, obs, exp);
            end
            ca_ready_i = (k >= 8);
        end
    endtask

    task automatic test_gaps();
        logic a0;
        logic [4:0] exp;
        logic [5:0] pat;
        pat = 6'b101001;  // bit i = data_valid in DATA cycle i: 1,0,0,1,0,1
        req_len_i = 16'd3; req_lat_i = 4'd1; req_proc_id_i = 1'b0;
        ca_ready_i = 1'b1; data_valid_i = 1'b0;
        a0 = ack_tgl_o;
        req_tgl_i = ~req_tgl_i;
        for (int k = 1; k <= 15; k++) begin
            @(negedge phy_clk_i);
            exp = {!(k >= 3 && k < 11), k == 3, (k >= 3 && k < 13), a0 ^ (k >= 13), k == 13};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL gaps k=%0d: got %b exp %b", k, obs, exp);
            end
            data_valid_i = (k >= 5 && k <= 10) ? pat[k-5] : 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic a0;
        logic [4:0] exp;
        req_len_i = 16'd1; req_lat_i = 4'd0; req_proc_id_i = 1'b0;
        ca_ready_i = 1'b1; data_valid_i = 1'b1;
        a0 = ack_tgl_o;
        req_tgl_i = ~req_tgl_i;
        for (int k = 1; k <= 14; k++) begin
            @(negedge phy_clk_i);
            exp = {!((k >= 3 && k < 5) || (k >= 8 && k < 10)), (k == 3 || k == 8),
                   ((k >= 3 && k < 7) || (k >= 8 && k < 12)),
                   a0 ^ (k >= 7) ^ (k >= 12), (k == 7 || k == 12)};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL b2b k=%0d: got %b exp %b", k, obs, exp);
            end
            if (k == 5) req_tgl_i = ~req_tgl_i;  // lands in first request's RECOV
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        req_len_i = 16'd4; req_lat_i = 4'd0; req_proc_id_i = 1'b1;
        ca_ready_i = 1'b1; data_valid_i = 1'b1;
        req_tgl_i = ~req_tgl_i;
        repeat (5) @(negedge phy_clk_i);
        tests++;
        if (obs[4] !== 1'b0 || obs[2] !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_in_data: got %b exp cs_no=0 running=1", obs);
        end
        rst_ni = 1'b0;
        req_tgl_i = 1'b0;
        #1;
        tests++;
        if (obs !== 5'b10000 || proc_id_o !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_async: got %b/%b exp 10000/0", obs, proc_id_o);
        end
        repeat (2) @(negedge phy_clk_i);
        rst_ni = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge phy_clk_i);
            tests++;
            if (obs !== 5'b10000) begin
                fails++;
                $display("FAIL rstmid_quiet k=%0d: got %b exp 10000", k, obs);
            end
        end
        req_len_i = 16'd1; req_proc_id_i = 1'b0;
        req_tgl_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge phy_clk_i);
            exp = {!(k >= 3 && k < 5), k == 3, (k >= 3 && k < 7), k >= 7, k == 7};
            tests++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL rstmid_next k=%0d: got %b exp %b", k, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_stall();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
